// File: rtl/logic_unit_if.sv
// Operand/result bundle between the decoder/controller and the logic/shift unit.
// The controller is the master; the execution unit is the slave.
interface logic_unit_if #(
    parameter int W = 8
);
    logic [3:0]   ctr1;
    logic [W-1:0] data1;
    logic [W-1:0] data2;
    logic [W-1:0] out;
    logic         ctr;
    logic         zf;
    logic         pf;

    modport master (
        output ctr1, data1, data2,
        input  out, ctr, zf, pf
    );

    modport slave (
        input  ctr1, data1, data2,
        output out, ctr, zf, pf
    );
endinterface

// File: rtl/logic_unit.sv
// Logic/shift execution unit: latches one of eight logic/shift results plus
// zero/parity flags, then holds ctr high for HOLD cycles while ignoring inputs.
module logic_unit #(
    parameter int W    = 8,
    parameter int HOLD = 3
) (
    input logic        clk,
    input logic        rst,
    logic_unit_if.slave bus
);
    localparam int SW = $clog2(W);
    localparam int CW = $clog2(HOLD + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   out_q, out_d;
    logic           ctr_q, ctr_d;
    logic           zf_q, zf_d;
    logic           pf_q, pf_d;

    logic [SW-1:0]  sh;
    logic [2*W-1:0] rot;
    logic [W-1:0]   res;

    // Rotate via a doubled operand so a zero amount needs no special case.
    always_comb begin
        sh  = bus.data2[SW-1:0];
        rot = {bus.data1, bus.data1} >> sh;
        case (bus.ctr1[2:0])
            3'd0:    res = bus.data1 & bus.data2;
            3'd1:    res = ~(bus.data1 & bus.data2);
            3'd2:    res = ~(bus.data1 | bus.data2);
            3'd3:    res = ~(bus.data1 ^ bus.data2);
            3'd4:    res = bus.data1 ^ bus.data2;
            3'd5:    res = bus.data1 | bus.data2;
            3'd6:    res = bus.data1 << sh;
            default: res = rot[W-1:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ctr_d   = ctr_q;
        zf_d    = zf_q;
        pf_d    = pf_q;
        case (state_q)
            IDLE: begin
                // Opcodes with the top bit clear belong to other units.
                if (bus.ctr1[3]) begin
                    out_d   = res;
                    zf_d    = (res == '0);
                    pf_d    = ^res;
                    ctr_d   = 1'b1;
                    cnt_d   = CW'(HOLD - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    ctr_d   = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            ctr_q   <= 1'b0;
            zf_q    <= 1'b0;
            pf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ctr_q   <= ctr_d;
            zf_q    <= zf_d;
            pf_q    <= pf_d;
        end
    end

    assign bus.out = out_q;
    assign bus.ctr = ctr_q;
    assign bus.zf  = zf_q;
    assign bus.pf  = pf_q;
endmodule

// File: tb/tb_logic_unit.sv
// Self-checking bench for logic_unit: directed scenarios plus random traffic
// compared every cycle against a cycle-count reference model.
module tb_logic_unit;
    localparam int W    = 8;
    localparam int HOLD = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic_unit_if #(.W(W)) bus ();

    logic_unit #(.W(W), .HOLD(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_out;
    logic         m_zf;
    logic         m_pf;
    int           m_left;   // cycles of ctr-high still owed after the last edge

    function automatic logic [W-1:0] ref_op(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
        logic [W-1:0] r;
        int n;
        n = int'(b) % W;
        r = a;
        case (op)
            4'b1000: r = a & b;
            4'b1001: r = ~(a & b);
            4'b1010: r = ~(a | b);
            4'b1011: r = ~(a ^ b);
            4'b1100: r = a ^ b;
            4'b1101: r = a | b;
            4'b1110: for (int i = 0; i < n; i++) r = {r[W-2:0], 1'b0};
            4'b1111: for (int i = 0; i < n; i++) r = {r[0], r[W-1:1]};
            default: r = a;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = '0; m_zf = 1'b0; m_pf = 1'b0; m_left = 0;
    endtask

    task automatic model_edge(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        if (m_left == 0) begin
            if (op[3]) begin
                r      = ref_op(op, a, b);
                m_out  = r;
                m_zf   = (r == '0);
                m_pf   = ($countones(r) % 2) == 1;
                m_left = HOLD;
            end
        end else begin
            m_left--;
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_out"}, 32'(bus.out), 32'(m_out));
        chk({tag, "_zf"},  32'(bus.zf),  32'(m_zf));
        chk({tag, "_pf"},  32'(bus.pf),  32'(m_pf));
        chk({tag, "_ctr"}, 32'(bus.ctr), 32'(m_left > 0));
    endtask

    // Drive inputs, take one edge, then compare against the model 1 time unit later.
    task automatic step(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.ctr1  = op;
        bus.data1 = a;
        bus.data2 = b;
        @(posedge clk);
        model_edge(op, a, b);
        #1;
        chk_model(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 4'b0000, 8'h00, 8'h00);
    endtask

    initial begin
        int ctr_seen;
        bus.ctr1 = 4'b0000; bus.data1 = '0; bus.data2 = '0;
        model_reset();
        #1;
        chk("rst_out", 32'(bus.out), 32'h0);
        chk("rst_ctr", 32'(bus.ctr), 32'h0);
        chk("rst_zf",  32'(bus.zf),  32'h0);
        chk("rst_pf",  32'(bus.pf),  32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // OR: first accept right after reset release, ctr high exactly HOLD cycles
        step("or", 4'b1101, 8'hA5, 8'h0F);
        chk("or_const_out", 32'(bus.out), 32'hAF);
        chk("or_const_pf",  32'(bus.pf),  32'h0);
        ctr_seen = 1;
        for (int i = 0; i < HOLD; i++) begin
            step("or_hold", 4'b0000, 8'h00, 8'h00);
            if (bus.ctr) ctr_seen++;
        end
        chk("or_ctr_cycles", 32'(ctr_seen), 32'(HOLD));

        // XNOR, then an opcode during BUSY that must be ignored
        step("xnor", 4'b1011, 8'hA5, 8'hA5);
        chk("xnor_const_out", 32'(bus.out), 32'hFF);
        step("busy_and", 4'b1000, 8'h00, 8'h00);
        idle(HOLD);
        chk("busy_ignored_out", 32'(bus.out), 32'hFF);
        chk("busy_ignored_ctr", 32'(bus.ctr), 32'h0);

        // Shifts with amount taken modulo W
        step("shl", 4'b1110, 8'h81, 8'h09);
        chk("shl_const_out", 32'(bus.out), 32'h02);
        idle(HOLD);
        step("ror", 4'b1111, 8'h01, 8'h03);
        chk("ror_const_out", 32'(bus.out), 32'h20);
        chk("ror_const_pf",  32'(bus.pf),  32'h1);
        idle(HOLD);
        step("ror0", 4'b1111, 8'h96, 8'h08);
        chk("ror0_const_out", 32'(bus.out), 32'h96);
        idle(HOLD);

        // Zero flag, then an opcode for another unit
        step("and", 4'b1000, 8'hF0, 8'h0F);
        chk("and_const_zf", 32'(bus.zf), 32'h1);
        idle(HOLD);
        step("foreign", 4'b0011, 8'hFF, 8'h01);
        chk("foreign_out", 32'(bus.out), 32'h00);
        chk("foreign_zf",  32'(bus.zf),  32'h1);
        chk("foreign_ctr", 32'(bus.ctr), 32'h0);

        // OR held continuously: ctr 1,1,1,0 repeating, result re-latched each period
        for (int i = 0; i < 12; i++) begin
            step("cont", 4'b1101, W'($urandom), W'($urandom));
            chk("cont_pattern", 32'(bus.ctr), 32'((i % 4) != 3));
        end
        idle(HOLD + 1);

        // Asynchronous reset mid-BUSY
        step("pre_rst", 4'b1100, 8'h01, 8'h00);
        #3; rst = 1'b1; #1;
        model_reset();
        chk("arst_ctr", 32'(bus.ctr), 32'h0);
        chk("arst_out", 32'(bus.out), 32'h0);
        chk("arst_zf",  32'(bus.zf),  32'h0);
        chk("arst_pf",  32'(bus.pf),  32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        step("post_rst_nand", 4'b1001, 8'hFF, 8'h0F);
        chk("nand_const_out", 32'(bus.out), 32'hF0);

        // Random traffic: mix of valid/foreign opcodes and random operands
        for (int i = 0; i < 300; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
            step("rand", op, W'($urandom), W'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/logic_unit.md
# logic_unit

Parametrised logic/shift execution unit for the basic processor datapath. It replaces the single-function OR unit with one block that executes eight logic and shift operations. Operands are the accumulator (`data1`) and immediate data (`data2`), both `W` bits wide. On an accepted opcode it registers the result and status flags, then holds `ctr` high for `HOLD` cycles so the controller can sequence the write-back.

## Interface
- `W`, 8, operand/result width; ≥ 2, power of two.
- `HOLD`, 3, cycles `ctr` stays high per operation; ≥ 1.
- `clk` input 1 rising-edge clock.
- `rst` input 1 reset, asynchronous, active-high.
- `ctr1` input 4 opcode from the decoder; sampled only in IDLE.
- `data1` input W accumulator operand.
- `data2` input W immediate operand; low `$clog2(W)` bits are the shift amount for shift ops.
- `out` output W registered result; holds until the next accepted op.
- `ctr` output 1 busy/valid strobe.
- `zf` output 1 zero flag: registered result == 0.
- `pf` output 1 odd-parity flag: XOR-reduce of registered result.

## Operation
- Opcode map; all other codes, including 0xxx, belong to other units and are ignored with no output change:
  - 1000 AND
  - 1001 NAND
  - 1010 NOR
  - 1011 XNOR
  - 1100 XOR
  - 1101 OR
  - 1110 SHL: logical left shift of `data1` by `data2 % W`, zero fill.
  - 1111 ROR: rotate `data1` right by `data2 % W`.
- Shift amount 0 returns `data1` unchanged. The amount is taken modulo W, so for W=8, `data2`=9 shifts by 1.
- All results are exactly W bits. Shifted-out bits are discarded; no carry output.
- FSM has two states, IDLE and BUSY. A down-counter `cnt` is `$clog2(HOLD+1)` bits wide.
  - In IDLE with a valid opcode at a rising edge: register `out`, `zf` and `pf` from the current inputs, set `ctr`=1, load `cnt`=HOLD-1, go to BUSY.
  - In IDLE with an invalid opcode: no change.
  - In BUSY: `ctr1`, `data1` and `data2` are ignored, including valid opcodes. Each edge with `cnt`≠0 decrements `cnt`. At the edge with `cnt`==0, clear `ctr` and go to IDLE.
- `out`, `zf` and `pf` change only on acceptance. They stay stable through BUSY and afterwards.

## Timing
- Accept edge k: `out`, `zf`, `pf` and `ctr`=1 are valid after edge k. Latency is 1 edge.
- `ctr` is high after edges k … k+HOLD-1 and low after edge k+HOLD, i.e. exactly HOLD cycles.
- The earliest next accept is edge k+HOLD+1, which leaves a mandatory one-cycle gap with `ctr` low. A valid opcode held continuously produces periodic pulses: HOLD cycles high, 1 cycle low, and the result is re-latched each period.
- HOLD=1: `ctr` is a single-cycle pulse; BUSY lasts one edge.
- Reset, asynchronous and taking effect immediately, including mid-BUSY:
  - `out`=0, `zf`=0, `pf`=0, `ctr`=0
  - state IDLE, `cnt`=0
- First accept is possible on the first rising edge after `rst` deasserts.
- `ctr1`, `data1` and `data2` must be stable around the accepting edge. They have no other setup requirement.

## Test plan
- Reset, then OR `data1`=8'hA5, `data2`=8'h0F at edge k. Required: `out`=8'hAF, `zf`=0, `pf`=0 (six ones). `ctr` is high for exactly 3 cycles, low after edge k+3.
- XNOR 8'hA5, 8'hA5, then during BUSY apply AND 8'h00, 8'h00. Required: `out`=8'hFF, `pf`=0. The BUSY-time opcode is ignored and `out` is still 8'hFF after `ctr` falls.
- SHL `data1`=8'h81, `data2`=8'h09. Required: `out`=8'h02. Then ROR `data1`=8'h01, `data2`=8'h03. Required: `out`=8'h20, `pf`=1.
- AND 8'hF0, 8'h0F. Required: `out`=8'h00, `zf`=1. Then opcode 4'b0011. Required: no change to `out` or `zf`, and `ctr` stays 0.
- Hold OR valid continuously for 12 cycles. Required: `ctr` pattern 1,1,1,0 repeating; accepts at edges k, k+4 and k+8.
- Assert `rst` asynchronously between edges while `ctr`=1. Required: `ctr`, `out`, `zf` and `pf` go to 0 before the next edge. After release, a NAND 8'hFF, 8'h0F is accepted on the first edge with `out`=8'hF0.
